adc_cbuf_wr_ctrl: RTL and testbench

Upstream neighbour of the circular-buffer acquisition state machine, running in the same 400 MHz ADC clock domain.
- Writes the continuous stream of packed ADC words (two 12-bit samples per 32-bit word) into the circular buffer RAM.
- On each accepted trigger, computes the buffer start address of the waveform (the write pointer minus the pre-trigger length).
- Pushes that address into a small FWFT trigger-address FIFO only after all post-trigger words are written, so the downstream reader can never overtake the writer.

---
 rtl/adc_cbuf_wr_ctrl_pkg.sv | 19 +
 rtl/adc_cbuf_wr_ctrl_if.sv | 35 +++
 rtl/adc_cbuf_wr_ctrl_trig_addr_fifo.sv | 67 ++++++
 rtl/adc_cbuf_wr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_adc_cbuf_wr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_cbuf_wr_ctrl_pkg.sv
// rtl/adc_cbuf_wr_ctrl_pkg.sv - shared types and defaults for the circular-buffer write controller
//
// Purpose: capture FSM state encoding and default geometry shared by the
// controller, its trigger-address FIFO and the interface.

package adc_cbuf_wr_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 12;  // 4096-word circular buffer
    localparam int DEF_FIFO_AW    = 2;   // 4-entry trigger-address FIFO
    localparam int DEF_DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_POST_TRIG = 2'd2,
        ST_PUSH      = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_cbuf_wr_ctrl_if.sv
// rtl/adc_cbuf_wr_ctrl_if.sv - ADC stream, buffer RAM write port and trigger-address FIFO read port
//
// Purpose: bundles the data-path handshakes of adc_cbuf_wr_ctrl.
// Signals:
//   adc_dat_valid/adc_dat        packed ADC word stream into the controller
//   cbuf_wr_en/addr/dat          registered circular-buffer RAM write port
//   trig_addr_rd_en              pop of the trigger-address FIFO head
//   trig_addr_dout/empty/full    FWFT head and status of that FIFO
// Modports: master = the controller, slave = its environment.

interface adc_cbuf_wr_ctrl_if #(
    parameter int ADDR_WIDTH = adc_cbuf_wr_ctrl_pkg::DEF_ADDR_WIDTH
);
    logic                  adc_dat_valid;
    logic [31:0]           adc_dat;
    logic                  cbuf_wr_en;
    logic [ADDR_WIDTH-1:0] cbuf_wr_addr;
    logic [31:0]           cbuf_wr_dat;
    logic                  trig_addr_rd_en;
    logic [ADDR_WIDTH-1:0] trig_addr_dout;
    logic                  trig_addr_empty;
    logic                  trig_addr_full;

    modport master (
        input  adc_dat_valid, adc_dat, trig_addr_rd_en,
        output cbuf_wr_en, cbuf_wr_addr, cbuf_wr_dat,
        output trig_addr_dout, trig_addr_empty, trig_addr_full
    );

    modport slave (
        output adc_dat_valid, adc_dat, trig_addr_rd_en,
        input  cbuf_wr_en, cbuf_wr_addr, cbuf_wr_dat,
        input  trig_addr_dout, trig_addr_empty, trig_addr_full
    );
endinterface

// File: rtl/adc_cbuf_wr_ctrl_trig_addr_fifo.sv
// rtl/adc_cbuf_wr_ctrl_trig_addr_fifo.sv - synchronous first-word-fall-through FIFO for waveform start addresses
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   wr_en, din      push; accepted when not full or when a pop happens in the same cycle
//   rd_en           pop of the head; ignored when empty
//   dout            head entry, valid whenever empty is low (reads 0 when empty)
//   empty, full     occupancy status

module trig_addr_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_rd;
    logic                  do_wr;

    assign empty = (count == '0);
    // count never exceeds DEPTH, so its top bit alone marks full
    assign full  = count[DEPTH_LOG2];
    assign dout  = empty ? '0 : mem[rd_ptr];

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_cbuf_wr_ctrl.sv
// rtl/adc_cbuf_wr_ctrl.sv - circular-buffer writer and trigger start-address generator for the ADC acquisition path
//
// Purpose: writes every packed ADC word into the circular buffer RAM, and on each
// accepted trigger edge computes the waveform start address (write pointer minus
// pre-trigger length). The address is pushed into the trigger-address FIFO only
// once all post-trigger words are written, so a reader can never overtake the writer.
// Ports:
//   clk, reset                  ADC clock, synchronous active-high reset
//   bus (master)                ADC stream in, RAM write port out, FIFO read port
//   acq_armed                   triggers accepted only while high
//   acq_trig                    trigger level, acted on at its rising edge
//   pre_trig_len, wfm_len       capture geometry in words, static while armed
//   trig_dropped_cnt            saturating count of rejected triggers
//   busy                        capture in progress (post-trigger fill or push)

module adc_cbuf_wr_ctrl
    import adc_cbuf_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_AW    = DEF_FIFO_AW,
    parameter int DROP_CNT_W = DEF_DROP_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_cbuf_wr_ctrl_if.master    bus,
    input  logic                  acq_armed,
    input  logic                  acq_trig,
    input  logic [ADDR_WIDTH-1:0] pre_trig_len,
    input  logic [ADDR_WIDTH-1:0] wfm_len,
    output logic [DROP_CNT_W-1:0] trig_dropped_cnt,
    output logic                  busy
);

    cap_state_t            state;
    cap_state_t            state_n;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] start_addr_n;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH-1:0] post_cnt_n;
    logic [ADDR_WIDTH:0]   post_diff;
    logic [ADDR_WIDTH-1:0] post_len;
    logic                  trig_d;
    logic                  trig_edge;
    logic                  valid;
    logic                  push;
    logic                  drop;

    assign valid     = bus.adc_dat_valid;
    assign trig_edge = acq_trig & ~trig_d;

    // One extra bit catches pre_trig_len > wfm_len; such a capture has no post-trigger words.
    assign post_diff = {1'b0, wfm_len} - {1'b0, pre_trig_len};
    assign post_len  = post_diff[ADDR_WIDTH] ? '0 : post_diff[ADDR_WIDTH-1:0];

    assign busy = (state == ST_POST_TRIG) || (state == ST_PUSH);

    // Write path: runs regardless of capture state, one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            bus.cbuf_wr_en   <= 1'b0;
            bus.cbuf_wr_addr <= '0;
            bus.cbuf_wr_dat  <= '0;
        end else begin
            bus.cbuf_wr_en <= valid;
            if (valid) begin
                bus.cbuf_wr_addr <= wr_ptr;
                bus.cbuf_wr_dat  <= bus.adc_dat;
                wr_ptr           <= wr_ptr + 1'b1;
            end
        end
    end

    // A word arriving in the edge cycle is the first post-trigger word, so it is
    // counted immediately. Going straight to PUSH when nothing remains keeps the
    // push exactly one cycle after the last post-trigger word.
    always_comb begin
        state_n      = state;
        start_addr_n = start_addr;
        post_cnt_n   = post_cnt;
        push         = 1'b0;
        drop         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acq_armed) begin
                    state_n = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!acq_armed) begin
                    state_n = ST_IDLE;
                end else if (trig_edge) begin
                    if (bus.trig_addr_full) begin
                        drop = 1'b1;
                    end else begin
                        start_addr_n = wr_ptr - pre_trig_len;
                        if ((post_len == '0) || ((post_len == ADDR_WIDTH'(1)) && valid)) begin
                            state_n = ST_PUSH;
                        end else begin
                            post_cnt_n = post_len - ADDR_WIDTH'(valid);
                            state_n    = ST_POST_TRIG;
                        end
                    end
                end
            end
            ST_POST_TRIG: begin
                drop = trig_edge;
                if (post_cnt == '0) begin
                    state_n = ST_PUSH;
                end else if (valid) begin
                    post_cnt_n = post_cnt - 1'b1;
                    if (post_cnt == ADDR_WIDTH'(1)) begin
                        state_n = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                drop    = trig_edge;
                push    = 1'b1;
                state_n = acq_armed ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            start_addr       <= '0;
            post_cnt         <= '0;
            trig_d           <= 1'b0;
            trig_dropped_cnt <= '0;
        end else begin
            state      <= state_n;
            start_addr <= start_addr_n;
            post_cnt   <= post_cnt_n;
            trig_d     <= acq_trig;
            if (drop && !(&trig_dropped_cnt)) begin
                trig_dropped_cnt <= trig_dropped_cnt + 1'b1;
            end
        end
    end

    trig_addr_fifo #(
        .WIDTH      (ADDR_WIDTH),
        .DEPTH_LOG2 (FIFO_AW)
    ) u_trig_addr_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push),
        .din   (start_addr),
        .rd_en (bus.trig_addr_rd_en),
        .dout  (bus.trig_addr_dout),
        .empty (bus.trig_addr_empty),
        .full  (bus.trig_addr_full)
    );

endmodule

// File: tb/tb_adc_cbuf_wr_ctrl.sv
// tb/tb_adc_cbuf_wr_ctrl.sv - self-checking bench for adc_cbuf_wr_ctrl

module tb_adc_cbuf_wr_ctrl;

    localparam int AW    = 12;
    localparam int FAW   = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;
    localparam int FDEP  = 4;

    logic clk = 1'b0;
    logic reset;
    logic acq_armed;
    logic acq_trig;
    logic [AW-1:0] pre_trig_len;
    logic [AW-1:0] wfm_len;
    logic [DW-1:0] trig_dropped_cnt;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adc_cbuf_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    adc_cbuf_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .FIFO_AW    (FAW),
        .DROP_CNT_W (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .acq_armed        (acq_armed),
        .acq_trig         (acq_trig),
        .pre_trig_len     (pre_trig_len),
        .wfm_len          (wfm_len),
        .trig_dropped_cnt (trig_dropped_cnt),
        .busy             (busy)
    );

    // Reference model: word count, trigger bookkeeping and a queue of start addresses.
    int          m_ptr;
    bit          m_trig_d;
    bit          m_listen;   // triggers currently accepted
    bit          m_capt;     // post-trigger words still to be written
    bit          m_push;     // start address goes into the FIFO at this coming edge
    int          m_rem;
    int          m_start;
    int          m_drops;
    int          q[$];
    bit          e_wr_en;
    int          e_addr;
    logic [31:0] e_dat;

    function automatic void model_step();
        bit edge_now;
        bit full_now;
        bit v;
        int ptr_now;
        int post;
        if (reset) begin
            m_ptr = 0; m_trig_d = 0; m_listen = 0; m_capt = 0; m_push = 0;
            m_rem = 0; m_start = 0; m_drops = 0; q.delete();
            e_wr_en = 0; e_addr = 0; e_dat = '0;
            return;
        end
        v        = bus.adc_dat_valid;
        edge_now = acq_trig && !m_trig_d;
        m_trig_d = acq_trig;
        full_now = (q.size() == FDEP);
        ptr_now  = m_ptr;
        post     = int'(wfm_len) - int'(pre_trig_len);
        if (post < 0) post = 0;
        e_wr_en = v;
        if (v) begin
            e_addr = m_ptr;
            e_dat  = bus.adc_dat;
            m_ptr  = (m_ptr + 1) % DEPTH;
        end
        if (bus.trig_addr_rd_en && q.size() > 0) void'(q.pop_front());
        if (m_push) begin
            q.push_back(m_start);
            m_push   = 0;
            m_listen = acq_armed;
            if (edge_now && m_drops < 65535) m_drops++;
        end else if (m_capt) begin
            if (edge_now && m_drops < 65535) m_drops++;
            if (v) m_rem--;
            if (m_rem == 0) begin
                m_capt = 0;
                m_push = 1;
            end
        end else if (m_listen) begin
            if (!acq_armed) begin
                m_listen = 0;
            end else if (edge_now) begin
                if (full_now) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    m_start = (ptr_now - int'(pre_trig_len) + DEPTH) % DEPTH;
                    m_rem   = post - int'(v);
                    if (m_rem <= 0) m_push = 1;
                    else            m_capt = 1;
                end
            end
        end else if (acq_armed) begin
            m_listen = 1;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit arm, input bit trg, input bit rd);
        bus.adc_dat_valid   = v;
        bus.adc_dat         = d;
        acq_armed           = arm;
        acq_trig            = trg;
        bus.trig_addr_rd_en = rd;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1, 32'hdead_beef, 1, 1, 1);
        reset = 1'b0;
        bus.adc_dat_valid = 0; acq_armed = 0; acq_trig = 0; bus.trig_addr_rd_en = 0;
        n_checks += 8;
        if (bus.cbuf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", bus.cbuf_wr_en); end
        if (bus.cbuf_wr_addr !== 12'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", bus.cbuf_wr_addr); end
        if (bus.cbuf_wr_dat !== 32'd0) begin n_fail++; $display("FAIL reset_wr_dat: got %0h expected 0", bus.cbuf_wr_dat); end
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", bus.trig_addr_empty); end
        if (bus.trig_addr_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", bus.trig_addr_full); end
        if (bus.trig_addr_dout !== 12'd0) begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", bus.trig_addr_dout); end
        if (trig_dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d expected 0", trig_dropped_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_write_path();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc(1, 32'(k), 0, 0, 0);
            n_checks += 3;
            if (bus.cbuf_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_en[%0d]: got %0b expected 1", k, bus.cbuf_wr_en); end
            if (bus.cbuf_wr_addr !== 12'(k)) begin n_fail++; $display("FAIL wr_addr[%0d]: got %0d expected %0d", k, bus.cbuf_wr_addr, k); end
            if (bus.cbuf_wr_dat !== 32'(k)) begin n_fail++; $display("FAIL wr_dat[%0d]: got %0d expected %0d", k, bus.cbuf_wr_dat, k); end
        end
        cyc(0, 0, 0, 0, 0);
        n_checks++;
        if (bus.cbuf_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_en_idle: got %0b expected 0", bus.cbuf_wr_en); end
        for (int k = 10; k < 4096; k++) cyc(1, 32'(k), 0, 0, 0);
        n_checks++;
        if (bus.cbuf_wr_addr !== 12'd4095) begin n_fail++; $display("FAIL wr_addr_top: got %0d expected 4095", bus.cbuf_wr_addr); end
        cyc(1, 32'h1234_5678, 0, 0, 0);
        n_checks += 2;
        if (bus.cbuf_wr_addr !== 12'd0) begin n_fail++; $display("FAIL wr_addr_wrap: got %0d expected 0", bus.cbuf_wr_addr); end
        if (bus.cbuf_wr_dat !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_dat_wrap: got %0h expected 12345678", bus.cbuf_wr_dat); end
    endtask

    // Capture at wr_ptr=100 (pre 16, wfm 64) with a second edge during the post-trigger fill.
    task automatic test_capture_and_drop();
        do_reset();
        pre_trig_len = 12'd16;
        wfm_len      = 12'd64;
        for (int k = 0; k < 100; k++) cyc(1, $urandom, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL cap_busy_start: got %0b expected 1", busy); end
        for (int i = 0; i < 48; i++) begin
            cyc(1, $urandom, 1, (i != 10), 0);
            n_checks += 2;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL cap_busy[%0d]: got %0b expected 1", i, busy); end
            if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL cap_empty[%0d]: got %0b expected 1", i, bus.trig_addr_empty); end
        end
        n_checks++;
        if (bus.cbuf_wr_addr !== 12'd147) begin n_fail++; $display("FAIL cap_last_addr: got %0d expected 147", bus.cbuf_wr_addr); end
        cyc(0, 0, 1, 1, 0);
        n_checks += 4;
        if (bus.trig_addr_empty !== 1'b0) begin n_fail++; $display("FAIL cap_empty_after_push: got %0b expected 0", bus.trig_addr_empty); end
        if (bus.trig_addr_dout !== 12'd84) begin n_fail++; $display("FAIL cap_dout: got %0d expected 84", bus.trig_addr_dout); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cap_busy_end: got %0b expected 0", busy); end
        if (trig_dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL cap_dropped: got %0d expected 1", trig_dropped_cnt); end
        cyc(0, 0, 1, 1, 1);
        n_checks++;
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL cap_single_entry: got %0b expected 1", bus.trig_addr_empty); end
    endtask

    task automatic test_zero_post();
        do_reset();
        pre_trig_len = 12'd16;
        wfm_len      = 12'd16;
        for (int k = 0; k < 5; k++) cyc(1, $urandom, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL zp_busy_push: got %0b expected 1", busy); end
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL zp_empty_push: got %0b expected 1", bus.trig_addr_empty); end
        cyc(0, 0, 1, 1, 0);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zp_busy_end: got %0b expected 0", busy); end
        if (bus.trig_addr_empty !== 1'b0) begin n_fail++; $display("FAIL zp_empty: got %0b expected 0", bus.trig_addr_empty); end
        if (bus.trig_addr_dout !== 12'd4085) begin n_fail++; $display("FAIL zp_dout: got %0d expected 4085", bus.trig_addr_dout); end
    endtask

    task automatic test_fifo_full();
        int ptr;
        int nv;
        int exp_a[4];
        do_reset();
        pre_trig_len = 12'd2;
        wfm_len      = 12'd4;
        ptr = 0;
        cyc(0, 0, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            nv = $urandom_range(1, 20);
            for (int k = 0; k < nv; k++) cyc(1, $urandom, 1, 0, 0);
            ptr += nv;
            exp_a[c] = (ptr - 2 + DEPTH) % DEPTH;
            cyc(0, 0, 1, 1, 0);
            cyc(1, $urandom, 1, 1, 0);
            cyc(1, $urandom, 1, 1, 0);
            ptr += 2;
            cyc(0, 0, 1, 1, 0);
            cyc(0, 0, 1, 0, 0);
        end
        n_checks += 2;
        if (bus.trig_addr_full !== 1'b1) begin n_fail++; $display("FAIL ff_full: got %0b expected 1", bus.trig_addr_full); end
        if (trig_dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL ff_dropped0: got %0d expected 0", trig_dropped_cnt); end
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        n_checks += 2;
        if (trig_dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL ff_dropped1: got %0d expected 1", trig_dropped_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ff_busy: got %0b expected 0", busy); end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (bus.trig_addr_dout !== 12'(exp_a[c])) begin n_fail++; $display("FAIL ff_pop[%0d]: got %0d expected %0d", c, bus.trig_addr_dout, exp_a[c]); end
            cyc(0, 0, 1, 0, 1);
        end
        n_checks += 2;
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL ff_empty: got %0b expected 1", bus.trig_addr_empty); end
        if (bus.trig_addr_full !== 1'b0) begin n_fail++; $display("FAIL ff_not_full: got %0b expected 0", bus.trig_addr_full); end
        cyc(0, 0, 1, 0, 1);
        n_checks += 3;
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL ff_pop_empty: got %0b expected 1", bus.trig_addr_empty); end
        if (bus.trig_addr_full !== 1'b0) begin n_fail++; $display("FAIL ff_pop_empty_full: got %0b expected 0", bus.trig_addr_full); end
        if (bus.trig_addr_dout !== 12'd0) begin n_fail++; $display("FAIL ff_pop_empty_dout: got %0d expected 0", bus.trig_addr_dout); end
    endtask

    task automatic test_abort_and_disarm();
        do_reset();
        pre_trig_len = 12'd4;
        wfm_len      = 12'd20;
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        for (int k = 0; k < 5; k++) cyc(1, $urandom, 1, 1, 0);
        reset = 1'b1;
        cyc(1, $urandom, 1, 1, 0);
        reset = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %0b expected 0", busy); end
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL ab_empty: got %0b expected 1", bus.trig_addr_empty); end
        if (bus.cbuf_wr_addr !== 12'd0) begin n_fail++; $display("FAIL ab_wr_addr: got %0d expected 0", bus.cbuf_wr_addr); end
        if (bus.cbuf_wr_en !== 1'b0) begin n_fail++; $display("FAIL ab_wr_en: got %0b expected 0", bus.cbuf_wr_en); end
        for (int k = 0; k < 20; k++) cyc(1, $urandom, 0, 0, 0);
        n_checks++;
        if (bus.trig_addr_empty !== 1'b1) begin n_fail++; $display("FAIL ab_no_push: got %0b expected 1", bus.trig_addr_empty); end
        // Disarm right after the trigger: the capture still completes.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        for (int k = 0; k < 16; k++) cyc(1, $urandom, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL da_busy: got %0b expected 0", busy); end
        if (bus.trig_addr_empty !== 1'b0) begin n_fail++; $display("FAIL da_empty: got %0b expected 0", bus.trig_addr_empty); end
        if (bus.trig_addr_dout !== 12'd16) begin n_fail++; $display("FAIL da_dout: got %0d expected 16", bus.trig_addr_dout); end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL da_idle_busy: got %0b expected 0", busy); end
        if (trig_dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL da_idle_dropped: got %0d expected 0", trig_dropped_cnt); end
    endtask

    task automatic test_random();
        int e_dout;
        do_reset();
        for (int seg = 0; seg < 10; seg++) begin
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
            pre_trig_len = 12'($urandom_range(0, 40));
            wfm_len      = 12'($urandom_range(0, 50));
            for (int i = 0; i < 300; i++) begin
                cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 19) != 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
                e_dout = (q.size() > 0) ? q[0] : 0;
                n_checks += 8;
                if (bus.cbuf_wr_en !== e_wr_en) begin n_fail++; $display("FAIL rnd_wr_en: got %0b expected %0b", bus.cbuf_wr_en, e_wr_en); end
                if (bus.cbuf_wr_addr !== 12'(e_addr)) begin n_fail++; $display("FAIL rnd_wr_addr: got %0d expected %0d", bus.cbuf_wr_addr, e_addr); end
                if (bus.cbuf_wr_dat !== e_dat) begin n_fail++; $display("FAIL rnd_wr_dat: got %0h expected %0h", bus.cbuf_wr_dat, e_dat); end
                if (bus.trig_addr_empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty: got %0b expected %0b", bus.trig_addr_empty, q.size() == 0); end
                if (bus.trig_addr_full !== (q.size() == FDEP)) begin n_fail++; $display("FAIL rnd_full: got %0b expected %0b", bus.trig_addr_full, q.size() == FDEP); end
                if (bus.trig_addr_dout !== 12'(e_dout)) begin n_fail++; $display("FAIL rnd_dout: got %0d expected %0d", bus.trig_addr_dout, e_dout); end
                if (trig_dropped_cnt !== 16'(m_drops)) begin n_fail++; $display("FAIL rnd_dropped: got %0d expected %0d", trig_dropped_cnt, m_drops); end
                if (busy !== (m_capt || m_push)) begin n_fail++; $display("FAIL rnd_busy: got %0b expected %0b", busy, m_capt || m_push); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.adc_dat_valid = 0; bus.adc_dat = 0; bus.trig_addr_rd_en = 0;
        acq_armed = 0; acq_trig = 0; pre_trig_len = 0; wfm_len = 0;
        test_reset();
        test_write_path();
        test_capture_and_drop();
        test_zero_post();
        test_fifo_full();
        test_abort_and_disarm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
